raster_cfg_ctrl: RTL
====================

RASTER_CFG_CTRL -- requirements
Module: raster_cfg_ctrl

Interface
REQ-001 Parameter: IMMEDIATE, 0, when 1 the commit does not wait for frame_end (applied one cycle after PEND entry).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_data  input  8  command/data byte stream.
REQ-005 in_valid  input  1  in_data valid; byte accepted when in_valid && in_ready at the clock edge.
REQ-006 in_ready  output  1  controller can accept a byte.
REQ-007 frame_end  input  1  one-cycle pulse from the raster scanner on the last pixel of the last line.
REQ-008 cfg_out  output  84  active timing: [10:0] x0, [21:11] x_fp, [32:22] x_s, [43:33] x1, [53:44] y0, [63:54] y_fp, [73:64] y_s, [83:74] y1.
REQ-009 cfg_update  output  1  one-cycle pulse in the cycle after cfg_out changes.
REQ-010 busy  output  1  high whenever state != IDLE.
REQ-011 err  output  1  one-cycle checksum-failure pulse.

Function
REQ-012 Storage: 16-byte shadow array S[0..15] and 16-byte active array A[0..15]; cfg_out = bits [83:0] of A packed little-endian (A[0] = bits 7:0); bits 84-127 are stored but unused.
REQ-013 States: IDLE, DATA, CHK, PEND; in_ready = 1 in IDLE, DATA and CHK, 0 in PEND.
REQ-014 IDLE: an accepted byte is a header; addr <= hdr[3:0], remaining count <= hdr[7:4] (N = hdr[7:4]+1 data bytes, 1..16); next state DATA.
REQ-015 DATA: each accepted byte writes S[addr]; addr increments modulo 16 (15 wraps to 0); after the Nth byte, next state CHK when checksum enabled, otherwise PEND.
REQ-016 Bytes are never dropped or duplicated; in_valid low in any state holds the state with no side effects.
REQ-017 PEND: when frame_end = 1 (or IMMEDIATE = 1), A <= S (all 16 bytes in one edge), next state IDLE; cfg_update = 1 in the following cycle only.
REQ-018 frame_end in the same cycle as the final byte accepted into PEND is ignored; the commit waits for the next frame_end.
REQ-019 frame_end in IDLE, DATA or CHK has no effect; A changes only on a PEND commit or on reset.
REQ-020 S is not copied back from A after a commit; bytes not written persist in S from earlier transactions.
REQ-021 busy is registered state decode, so it goes high the cycle after the header is accepted.

Reset
REQ-022 On clk edge with rst_n = 0: state <= IDLE, addr/count <= 0, cfg_update <= 0, err <= 0, checksum accumulator <= 0.
REQ-023 Reset loads A and S with the 800x525 default: x0 = -48 (0x7D0), x_fp = 640, x_s = 656, x1 = 751, y0 = -33 (0x3DF), y_fp = 480, y_s = 490, y1 = 491; bits 84-127 = 0.
REQ-024 Reset mid-transaction (DATA, CHK or PEND) discards the transaction; no commit, cfg_update stays 0.
REQ-025 in_ready = 1 in the first cycle after reset release.

Configuration
REQ-026 Macro RASTER_CFG_CHECKSUM_EN defined: CHK state exists; one extra byte is accepted after the data; the XOR of header, all data bytes and checksum byte equal to 0 -> PEND; otherwise S <= A (restore), err = 1 for one cycle, next state IDLE.
REQ-027 Macro RASTER_CFG_CHECKSUM_EN not defined: CHK state and accumulator are absent, DATA goes directly to PEND, and err is tied to 0.

Verification
REQ-028 Reset release -> cfg_out equals the REQ-023 defaults, busy = 0, in_ready = 1, cfg_update = 0.
REQ-029 Header 0x10, bytes 0x80,0x02, no frame_end for 100 cycles -> in_ready = 0, cfg_out unchanged; frame_end pulse -> next cycle x0 = 0x280, cfg_update one cycle, busy = 0.
REQ-030 Header 0x1F, bytes 0xAA,0xBB -> S[15] = 0xAA, S[0] = 0xBB (wrap); after frame_end, cfg_out[7:0] = 0xBB.
REQ-031 frame_end asserted in the same cycle as the last data byte -> no commit; commit occurs on the next frame_end.
REQ-032 RASTER_CFG_CHECKSUM_EN: header 0x00, data 0x12, checksum 0x13 -> err pulse, S restored, no commit; checksum 0x12 -> commit on frame_end.
REQ-033 rst_n low while in PEND -> IDLE, cfg_out = defaults, no cfg_update; IMMEDIATE = 1 run -> commit without frame_end.

Source files
------------

// File: rtl/raster_cfg_ctrl_if.sv
// Byte-stream command port into the raster timing controller.
// Valid/ready handshake; a byte transfers on a clock edge with in_valid && in_ready.
interface raster_cfg_ctrl_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/raster_cfg_ctrl.sv
// Shadow/active raster timing registers loaded by header+data byte packets; commit on frame_end.
// One-cycle accept per byte, stalls (in_ready=0) while a commit is pending; optional RASTER_CFG_CHECKSUM_EN.
module raster_cfg_ctrl #(
  parameter bit IMMEDIATE = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  raster_cfg_ctrl_if.slave        in_if,
  input  logic                    frame_end,
  output logic [83:0]             cfg_out,
  output logic                    cfg_update,
  output logic                    busy,
  output logic                    err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
`ifdef RASTER_CFG_CHECKSUM_EN
  localparam logic [1:0] CHK  = 2'd2;
`endif
  localparam logic [1:0] PEND = 2'd3;

  // 800x525 timing: x0=-48, x_fp=640, x_s=656, x1=751, y0=-33, y_fp=480, y_s=490, y1=491
  localparam logic [127:0] CFG_DEFAULT = {44'd0,
                                          10'd491, 10'd490, 10'd480, 10'h3DF,
                                          11'd751, 11'd656, 11'd640, 11'h7D0};

  logic [1:0]       state;
  logic [3:0]       addr;
  logic [3:0]       cnt;
  logic [15:0][7:0] shadow;
  logic [15:0][7:0] active;
  logic             accept;
  logic             commit;
  logic             cfg_unused;

  assign in_if.in_ready = (state != PEND);
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign commit         = (state == PEND) && (frame_end || IMMEDIATE);
  assign busy           = (state != IDLE);
  assign cfg_out        = {active[10][3:0], active[9:0]};
  // Upper stored bytes have no output field.
  assign cfg_unused     = ^{active[15:11], active[10][7:4]};

`ifdef RASTER_CFG_CHECKSUM_EN
  logic [7:0] chk_acc;
  logic       chk_ok;
  assign chk_ok = ((chk_acc ^ in_if.in_data) == 8'h00);
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= 4'd0;
      cnt        <= 4'd0;
      cfg_update <= 1'b0;
      shadow     <= CFG_DEFAULT;
      active     <= CFG_DEFAULT;
`ifdef RASTER_CFG_CHECKSUM_EN
      err        <= 1'b0;
      chk_acc    <= 8'h00;
`endif
    end else begin
      cfg_update <= commit;
`ifdef RASTER_CFG_CHECKSUM_EN
      err        <= 1'b0;
`endif
      case (state)
        IDLE: if (accept) begin
          addr  <= in_if.in_data[3:0];
          cnt   <= in_if.in_data[7:4];
          state <= DATA;
`ifdef RASTER_CFG_CHECKSUM_EN
          chk_acc <= in_if.in_data;
`endif
        end
        DATA: if (accept) begin
          shadow[addr] <= in_if.in_data;
          addr         <= addr + 4'd1;
          cnt          <= cnt - 4'd1;
`ifdef RASTER_CFG_CHECKSUM_EN
          chk_acc      <= chk_acc ^ in_if.in_data;
          if (cnt == 4'd0) state <= CHK;
`else
          if (cnt == 4'd0) state <= PEND;
`endif
        end
`ifdef RASTER_CFG_CHECKSUM_EN
        CHK: if (accept) begin
          if (chk_ok) begin
            state <= PEND;
          end else begin
            // Bad packet: throw away everything staged since the last commit.
            shadow <= active;
            err    <= 1'b1;
            state  <= IDLE;
          end
        end
`endif
        PEND: if (commit) begin
          active <= shadow;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
